// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer and its ShiftRegister datapath.
//   state_t     : controller FSM states (IDLE, LOAD, SHIFT, DONE)
//   SEL_*       : ShiftRegister select encodings
//   shift_sel() : select code for a shift in the given direction
package shift_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  // dir=1 shifts left (MSB leaves first), dir=0 shifts right (LSB leaves first)
  function automatic logic [1:0] shift_sel(input logic dir);
    return dir ? SEL_SHL : SEL_SHR;
  endfunction

endpackage

// File: rtl/shift_register.sv
// Generic WIDTH-bit ShiftRegister datapath driven by shift_sequencer.
// Ports:
//   clk    : clock, rising edge
//   data   : parallel load value
//   select : 11 load, 01 shift right, 10 shift left, 00 hold
//   e      : enable; register holds when low
//   out    : current register contents
// Shifts are zero-filling in both directions.
module shift_register
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       select,
  input  logic             e,
  output logic [WIDTH-1:0] out
);

  always_ff @(posedge clk) begin
    if (e) begin
      unique case (select)
        SEL_LOAD: out <= data;
        SEL_SHR:  out <= out >> 1;
        SEL_SHL:  out <= out << 1;
        default:  out <= out;
      endcase
    end
  end

endmodule

// File: rtl/shift_sequencer_top.sv
// Integration wrapper: shift_sequencer driving one shift_register.
// Ports mirror the controller's job, control and status ports; the
// ShiftRegister connection is internal.
module shift_sequencer_top
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic             req_dir,
  input  logic [CNT_W-1:0] req_count,
  input  logic             pause,
  input  logic             abort,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] sr_data;
  logic [1:0]       sr_select;
  logic             sr_e;
  logic [WIDTH-1:0] sr_out;

  shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_seq (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_dir   (req_dir),
    .req_count (req_count),
    .pause     (pause),
    .abort     (abort),
    .sr_data   (sr_data),
    .sr_select (sr_select),
    .sr_e      (sr_e),
    .sr_out    (sr_out),
    .ser_bit   (ser_bit),
    .ser_valid (ser_valid),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  shift_register #(.WIDTH(WIDTH)) u_sr (
    .clk    (clk),
    .data   (sr_data),
    .select (sr_select),
    .e      (sr_e),
    .out    (sr_out)
  );

endmodule

// File: rtl/shift_sequencer.sv
// Controller that sequences one ShiftRegister: load a value, shift it N times
// in the requested direction, stream the departing bits, report the result.
// Ports:
//   clk, rst     : clock; synchronous active-low reset
//   req_valid/req_ready/req_data/req_dir/req_count : job handshake
//   pause        : stall shifting while high
//   abort        : cancel the job (honoured in LOAD and SHIFT only)
//   sr_data/sr_select/sr_e : registered drive to the ShiftRegister
//   sr_out       : ShiftRegister contents
//   ser_bit/ser_valid : bit leaving the register on this cycle's edge
//   busy, done, result : job status, completion pulse, final contents
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic             req_dir,
  input  logic [CNT_W-1:0] req_count,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] sr_data,
  output logic [1:0]       sr_select,
  output logic             sr_e,
  input  logic [WIDTH-1:0] sr_out,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

  state_t           state;
  logic             dir_q;
  logic [CNT_W-1:0] count;

  // More than WIDTH shifts would only keep shifting zeros in
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
    return (c > MAX_CNT) ? MAX_CNT : c;
  endfunction

  assign req_ready = (state == IDLE);

  // sr_e is registered, so a shift happens at the edge closing any SHIFT
  // cycle in which sr_e is high; the departing bit is visible beforehand.
  assign ser_valid = (state == SHIFT) && sr_e;
  assign ser_bit   = ser_valid && (dir_q ? sr_out[WIDTH-1] : sr_out[0]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      sr_data   <= '0;
      sr_select <= SEL_HOLD;
      sr_e      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      count     <= '0;
      dir_q     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          sr_select <= SEL_HOLD;
          sr_e      <= 1'b0;
          busy      <= 1'b0;
          if (req_valid) begin
            sr_data   <= req_data;
            dir_q     <= req_dir;
            count     <= clamp_count(req_count);
            sr_select <= SEL_LOAD;
            sr_e      <= 1'b1;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end

        LOAD: begin
          if (abort) begin
            sr_select <= SEL_HOLD;
            sr_e      <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (count != '0) begin
            sr_select <= shift_sel(dir_q);
            sr_e      <= ~pause;
            state     <= SHIFT;
          end else begin
            sr_select <= SEL_HOLD;
            sr_e      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end

        SHIFT: begin
          if (abort) begin
            sr_select <= SEL_HOLD;
            sr_e      <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (sr_e && count == CNT_W'(1)) begin
            // last shift issues on this edge
            count     <= '0;
            sr_select <= SEL_HOLD;
            sr_e      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            if (sr_e) count <= count - CNT_W'(1);
            sr_e <= ~pause;
          end
        end

        DONE: begin
          // sr_out already includes the final shift edge
          result <= sr_out;
          busy   <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
